// File: rtl/rhs_pkg.sv
// Shared opcodes, response constants, FSM states and the command classifier
// used by the RHS2116-style SPI responder.
package rhs_pkg;

    localparam logic [1:0]  OP_CONVERT    = 2'b00;
    localparam logic [1:0]  OP_CLEAR      = 2'b01;
    localparam logic [1:0]  OP_WRITE      = 2'b10;
    localparam logic [1:0]  OP_READ       = 2'b11;

    localparam logic [31:0] CLEAR_WORD    = 32'h6A00_0000;
    localparam logic [15:0] RESP_WRITE_HI = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        CMD_CONVERT,
        CMD_WRITE,
        CMD_READ,
        CMD_CLEAR,
        CMD_NOP
    } cmd_kind_e;

    // Only the exact CLEAR word is a CLEAR; every other 01 word is a no-op.
    function automatic cmd_kind_e decode_cmd(input logic [31:0] cmd);
        cmd_kind_e kind;
        case (cmd[31:30])
            OP_CONVERT: kind = CMD_CONVERT;
            OP_WRITE:   kind = CMD_WRITE;
            OP_READ:    kind = CMD_READ;
            OP_CLEAR:   kind = (cmd == CLEAR_WORD) ? CMD_CLEAR : CMD_NOP;
            default:    kind = CMD_NOP;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/rhs_spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus single-cycle
// rising/falling edge pulses derived from the synchronized level.
module rhs_spi_sync (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    // [0] metastability stage, [1] synchronized level, [2] previous level
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[1];
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/rhs_spi_responder.sv
// RHS2116-style SPI responder: decodes 32-bit frames and returns each response two frames later.
// Define RHS_RESP_REGFILE_EN to implement the REG_COUNT x 16 register file behind WRITE/READ.
module rhs_spi_responder
    import rhs_pkg::*;
#(
    parameter int unsigned STARTING_SEED = 0,
    parameter int unsigned REG_COUNT     = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       SCLK,
    input  logic       CS,
    input  logic       MOSI,
    output logic       MISO,
    output logic [7:0] channel_out,
    output logic       frame_done,
    output logic       frame_error
);

    localparam logic [7:0] SEED8 = 8'(STARTING_SEED);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sync;

    rhs_spi_sync u_sync_sclk (.clk(clk), .rstn(rstn), .din(SCLK), .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    rhs_spi_sync u_sync_cs   (.clk(clk), .rstn(rstn), .din(CS),   .dout(cs_lvl),   .rise(cs_rise),   .fall(cs_fall));
    rhs_spi_sync u_sync_mosi (.clk(clk), .rstn(rstn), .din(MOSI), .dout(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    state_e           state_q, state_d;
    logic [31:0]      cmd_q, cmd_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [31:0]      out_sr_q, out_sr_d;
    logic             miso_q, miso_d;
    logic [5:0]       channel_q, channel_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [1:0][31:0] pipe_q, pipe_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_error_q, frame_error_d;

    cmd_kind_e   kind;
    logic        frame_ok;
    logic [5:0]  conv_ch;
    logic [15:0] rd_data;
    logic [31:0] resp;

    assign kind     = decode_cmd(cmd_q);
    assign frame_ok = (bit_cnt_q == 6'd32);
    assign conv_ch  = cmd_q[21:16];

    always_comb begin
        case (kind)
            CMD_CONVERT: resp = {8'h00, 8'(conv_ch), SEED8 + 8'(conv_ch), frame_cnt_q};
            CMD_WRITE:   resp = {RESP_WRITE_HI, cmd_q[15:0]};
            CMD_READ:    resp = {16'h0000, rd_data};
            default:     resp = '0;
        endcase
    end

`ifdef RHS_RESP_REGFILE_EN
    localparam int unsigned AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic [15:0]   regs_q [REG_COUNT];
    logic [15:0]   regs_d [REG_COUNT];
    logic          addr_hit;
    logic [AW-1:0] addr_idx;
    logic          wr_en;

    assign addr_hit = 32'(cmd_q[23:16]) < REG_COUNT;
    assign addr_idx = AW'(cmd_q[23:16]);
    assign wr_en    = (state_q == DONE) && frame_ok && (kind == CMD_WRITE) && addr_hit;
    assign rd_data  = addr_hit ? regs_q[addr_idx] : 16'h0000;

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[addr_idx] = cmd_q[15:0];
        end
    end

    // NOTE: the register file is reset explicitly, so it is built from flops rather than block RAM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end
`else
    logic [31:0] unused_reg_count;

    assign unused_reg_count = REG_COUNT;
    assign rd_data          = 16'h0000;
`endif

    // NOTE: every signal gets a default first, so no path through this block infers a latch.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        bit_cnt_d     = bit_cnt_q;
        out_sr_d      = out_sr_q;
        miso_d        = miso_q;
        channel_d     = channel_q;
        frame_cnt_d   = frame_cnt_q;
        pipe_d        = pipe_q;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                // A CS rise wins over a coincident SCLK rise; that last edge is dropped.
                if (cs_rise) begin
                    state_d = DONE;
                end else if (sclk_rise) begin
                    cmd_d     = {cmd_q[30:0], mosi_lvl};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            DONE: begin
                if (frame_ok) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    pipe_d       = {pipe_q[0], resp};
                    if (kind == CMD_CONVERT) begin
                        channel_d = conv_ch;
                    end
                end else begin
                    frame_error_d = 1'b1;
                end
                if (cs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A frame starting in DONE must see the response being pushed this cycle.
        if (cs_lvl) begin
            miso_d = 1'b0;
        end else if (cs_fall && (state_q != SHIFT)) begin
            out_sr_d = ((state_q == DONE) && frame_ok) ? pipe_q[0] : pipe_q[1];
            miso_d   = out_sr_d[31];
        end else if (sclk_fall && (state_q == SHIFT)) begin
            out_sr_d = {out_sr_q[30:0], 1'b0};
            miso_d   = out_sr_q[30];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            bit_cnt_q     <= '0;
            out_sr_q      <= '0;
            miso_q        <= 1'b0;
            channel_q     <= '0;
            frame_cnt_q   <= '0;
            pipe_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            bit_cnt_q     <= bit_cnt_d;
            out_sr_q      <= out_sr_d;
            miso_q        <= miso_d;
            channel_q     <= channel_d;
            frame_cnt_q   <= frame_cnt_d;
            pipe_q        <= pipe_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign MISO        = miso_q;
    assign channel_out = {2'b00, channel_q};
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_rhs_spi_responder.sv
// Directed bench for rhs_spi_responder (STARTING_SEED=16, REG_COUNT=32): acts as SPI master
// with SCLK at 1/6 of clk and checks responses, pulses, wrap-around and mid-frame reset.
module tb_rhs_spi_responder;

    logic       clk = 1'b0;
    logic       rstn;
    logic       SCLK;
    logic       CS;
    logic       MOSI;
    logic       MISO;
    logic [7:0] channel_out;
    logic       frame_done;
    logic       frame_error;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rx_word;
    int          done_cnt;
    int          err_cnt;
    int          done_pos;
    logic        miso_at2;
    logic        miso_at3;
    logic        miso_idle;
    logic [31:0] exp_rd;

    rhs_spi_responder #(
        .STARTING_SEED(16),
        .REG_COUNT    (32)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .SCLK       (SCLK),
        .CS         (CS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .channel_out(channel_out),
        .frame_done (frame_done),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drop CS and note MISO 2 and 3 cycles later (bit 31 is due on the third).
    task automatic cs_low();
        CS = 1'b0;
        @(negedge clk);
        @(negedge clk);
        miso_at2 = MISO;
        @(negedge clk);
        miso_at3 = MISO;
    endtask

    // MISO is sampled 3 cycles after each SCLK fall, MOSI set up 1 cycle before each rise.
    task automatic send_bits(input logic [31:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx_word[31-i] = MISO;
            MOSI = word[31-i];
            @(negedge clk);
            SCLK = 1'b1;
            repeat (2) @(negedge clk);
            SCLK = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    // Raise CS and count done/error pulses over a fixed 10-cycle window.
    task automatic cs_high_window();
        MOSI = 1'b0;
        CS   = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (frame_done) begin
                done_cnt++;
                if (done_pos == 0) done_pos = k;
            end
            if (frame_error) err_cnt++;
            miso_idle = MISO;
        end
    endtask

    task automatic clear_obs();
        rx_word  = '0;
        done_cnt = 0;
        err_cnt  = 0;
        done_pos = 0;
    endtask

    task automatic frame(input logic [31:0] word, input int nbits);
        clear_obs();
        cs_low();
        send_bits(word, nbits);
        cs_high_window();
    endtask

    initial begin
`ifdef RHS_RESP_REGFILE_EN
        exp_rd = 32'h0000_BEEF;
`else
        exp_rd = 32'h0000_0000;
`endif
        rstn = 1'b0;
        SCLK = 1'b0;
        CS   = 1'b1;
        MOSI = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_channel", 32'(channel_out), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_error", 32'(frame_error), 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Three CONVERTs on channel 5; seed 16 -> 0x15 in the sample high byte.
        frame(32'h0005_0000, 32);
        check("conv1_rx", rx_word, 32'h0);
        check("conv1_done_cnt", 32'(done_cnt), 32'd1);
        check("conv1_done_pos", 32'(done_pos), 32'd4);
        frame(32'h0005_0000, 32);
        check("conv2_rx", rx_word, 32'h0);
        frame(32'h0005_0000, 32);
        check("conv3_rx", rx_word, 32'h0005_1500);
        check("conv3_channel", 32'(channel_out), 32'd5);

        // WRITE addr 3, READ addr 3, then two CONVERTs to flush the responses.
        frame(32'h8003_BEEF, 32);
        check("write_rx", rx_word, 32'h0005_1501);
        frame(32'hC003_0000, 32);
        check("read_rx", rx_word, 32'h0005_1502);
        frame(32'h0005_0000, 32);
        check("write_resp", rx_word, 32'hFFFF_BEEF);
        check("miso_before_bit31", 32'(miso_at2), 32'd0);
        check("miso_bit31_lat3", 32'(miso_at3), 32'd1);
        check("miso_idle_cs_high", 32'(miso_idle), 32'd0);
        frame(32'h0005_0000, 32);
        check("read_resp", rx_word, exp_rd);

        // READ beyond the register file, a CONVERT on channel 9, CLEAR.
        frame(32'hC0C8_0000, 32);
        check("read200_rx", rx_word, 32'h0005_1505);
        frame(32'h0009_0000, 32);
        check("conv9_rx", rx_word, 32'h0005_1506);
        check("conv9_channel", 32'(channel_out), 32'd9);
        frame(32'h6A00_0000, 32);
        check("read200_resp", rx_word, 32'h0);
        check("clear_done_cnt", 32'(done_cnt), 32'd1);

        // Truncated 20-bit frame: error pulse only, nothing committed.
        frame(32'h0007_0000, 20);
        check("short_rx_hi", 32'(rx_word[31:12]), 32'h0_0091);
        check("short_err_cnt", 32'(err_cnt), 32'd1);
        check("short_done_cnt", 32'(done_cnt), 32'd0);
        check("short_channel", 32'(channel_out), 32'd9);
        frame(32'h0002_0000, 32);
        check("after_short_rx", rx_word, 32'h0009_1908);
        check("after_short_done", 32'(done_cnt), 32'd1);
        check("after_short_err", 32'(err_cnt), 32'd0);
        frame(32'h0002_0000, 32);
        check("clear_resp", rx_word, 32'h0);
        frame(32'h0000_0000, 32);
        check("frame_cnt_kept", rx_word, 32'h0002_120A);

        // 256 CONVERTs on channel 0 (frames 13..268): frame_cnt wraps 0xFF -> 0x00.
        for (int i = 0; i < 256; i++) begin
            frame(32'h0000_0000, 32);
            if (13 + i == 257) check("wrap_ff", rx_word, 32'h0000_10FF);
            if (13 + i == 258) check("wrap_00", rx_word, 32'h0000_1000);
        end

        // Reset pulse in the middle of a frame (after 15 bits).
        frame(32'h0003_0000, 32);
        check("pre_reset_channel", 32'(channel_out), 32'd3);
        clear_obs();
        cs_low();
        send_bits(32'hC003_0000, 15);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("midrst_miso", 32'(MISO), 32'd0);
        check("midrst_channel", 32'(channel_out), 32'd0);
        check("midrst_done", 32'(frame_done), 32'd0);
        check("midrst_error", 32'(frame_error), 32'd0);
        send_bits(32'h0000_0000, 17);
        cs_high_window();
        check("midrst_tail_done", 32'(done_cnt), 32'd0);
        check("midrst_tail_err", 32'(err_cnt), 32'd0);
        frame(32'h0006_0000, 32);
        check("post_rst_done", 32'(done_cnt), 32'd1);
        check("post_rst_rx0", rx_word, 32'h0);
        check("post_rst_channel", 32'(channel_out), 32'd6);
        frame(32'h0006_0000, 32);
        check("post_rst_rx1", rx_word, 32'h0);
        frame(32'h0006_0000, 32);
        check("post_rst_rx2", rx_word, 32'h0006_1600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
